// File: rtl/vecunit_fp_pkg.sv
// Shared FP32 constants and operand types for the vector FP unit.
package vecunit_fp_pkg;

  localparam int unsigned FP32_BIAS    = 127;
  localparam int unsigned FP32_EXP_MAX = 255;
  localparam int unsigned SIG_W        = 24;
  localparam int unsigned PROD_W       = 48;

  // Round codes carried alongside each element
  localparam logic [1:0] RM_TRUNC   = 2'b00;
  localparam logic [1:0] RM_RNE     = 2'b01;
  localparam logic [1:0] RM_POS_INF = 2'b10;
  localparam logic [1:0] RM_NEG_INF = 2'b11;

  typedef struct packed {
    logic             sign;
    logic [7:0]       exp;
    logic [SIG_W-1:0] sig;
  } fp32_unpacked_t;

  // Split an FP32 word into sign, biased exponent and significand with hidden one.
  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.sig  = {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/mant_mul_pipe.sv
// Two-stage 24x24 unsigned multiplier: split partial products, then registered sum.
module mant_mul_pipe
  import vecunit_fp_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [SIG_W-1:0]  a_i,
  input  logic [SIG_W-1:0]  b_i,
  output logic              valid_o,
  output logic [PROD_W-1:0] prod_o
);

  localparam int unsigned HALF_W = SIG_W / 2;
  localparam int unsigned PP_W   = SIG_W + HALF_W;

  logic [PP_W-1:0]   w_pp_lo, w_pp_hi;
  logic [PROD_W-1:0] w_sum;
  logic [PP_W-1:0]   r_pp_lo, r_pp_hi;
  logic              r_v2, r_v3;
  logic [PROD_W-1:0] r_prod;

  // Partial products against the low and high halves of b
  always_comb begin
    w_pp_lo = PP_W'(a_i) * PP_W'(b_i[HALF_W-1:0]);
    w_pp_hi = PP_W'(a_i) * PP_W'(b_i[SIG_W-1:HALF_W]);
    w_sum   = PROD_W'(r_pp_lo) + (PROD_W'(r_pp_hi) << HALF_W);
  end

  // Stage valids: flush clears, otherwise advance only on the shared enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (flush_i) begin
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (en_i) begin
      r_v2 <= valid_i;
      r_v3 <= r_v2;
    end
  end

  // Data registers advance with the pipe, bubbles included
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pp_lo <= '0;
      r_pp_hi <= '0;
      r_prod  <= '0;
    end else if (en_i) begin
      r_pp_lo <= w_pp_lo;
      r_pp_hi <= w_pp_hi;
      r_prod  <= w_sum;
    end
  end

  assign valid_o = r_v3;
  assign prod_o  = r_prod;

endmodule

// File: rtl/vec_fp32_mul_front.sv
// FP32 multiply front end: unpack, exponent sum, class flags and exact significand product.
module vec_fp32_mul_front
  import vecunit_fp_pkg::*;
#(
  parameter int unsigned BIAS = FP32_BIAS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        elem_valid_i,
  input  logic        mask_i,
  input  logic [1:0]  rm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        sa_o,
  output logic        sb_o,
  output logic        elem_valid_o,
  output logic        mask_o,
  output logic [1:0]  round_code_o,
  output logic [47:0] mult_result_o,
  output logic [7:0]  exponent_sum_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  localparam logic signed [9:0] S_MAX = 10'sd254;
  localparam logic signed [9:0] S_MIN = 10'sd1;

  logic              w_en, w_accept;
  fp32_unpacked_t    w_a, w_b;
  logic [9:0]        w_s;
  logic              w_zero, w_inf;
  logic              w_ovf, w_unf, w_kill;
  logic [7:0]        w_exp;
  logic [SIG_W-1:0]  w_ma;
  logic              w_mul_valid;
  logic [PROD_W-1:0] w_prod;

  // Stage 1 registers
  logic              r1_valid;
  fp32_unpacked_t    r1_a, r1_b;
  logic signed [9:0] r1_s;
  logic              r1_zero, r1_inf, r1_ev, r1_mask;
  logic [1:0]        r1_rm;
  // Stage 2 registers
  logic [7:0]        r2_exp;
  logic              r2_ovf, r2_unf, r2_sa, r2_sb, r2_ev, r2_mask;
  logic [1:0]        r2_rm;
  // Stage 3 (output) registers
  logic [7:0]        r3_exp;
  logic              r3_ovf, r3_unf, r3_sa, r3_sb, r3_ev, r3_mask;
  logic [1:0]        r3_rm;

  assign w_en       = ~out_valid_o | out_ready_i;
  assign in_ready_o = w_en;
  assign w_accept   = in_valid_i & w_en & ~flush_i;

  // Unpack operands, form the 10-bit biased exponent sum and operand classes
  always_comb begin
    w_a    = fp32_unpack(a_i);
    w_b    = fp32_unpack(b_i);
    w_s    = {2'b00, w_a.exp} + {2'b00, w_b.exp} - 10'(BIAS);
    w_zero = (w_a.exp == 8'd0) | (w_b.exp == 8'd0);
    w_inf  = (w_a.exp == 8'(FP32_EXP_MAX)) | (w_b.exp == 8'(FP32_EXP_MAX));
  end

  // Stage 1 valid: flush beats accept, everything holds while stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r1_valid <= 1'b0;
    end else if (flush_i) begin
      r1_valid <= 1'b0;
    end else if (w_en) begin
      r1_valid <= w_accept;
    end
  end

  // Stage 1 data capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r1_a    <= '0;
      r1_b    <= '0;
      r1_s    <= '0;
      r1_zero <= 1'b0;
      r1_inf  <= 1'b0;
      r1_ev   <= 1'b0;
      r1_mask <= 1'b0;
      r1_rm   <= '0;
    end else if (w_en) begin
      r1_a    <= w_a;
      r1_b    <= w_b;
      r1_s    <= w_s;
      r1_zero <= w_zero;
      r1_inf  <= w_inf;
      r1_ev   <= elem_valid_i;
      r1_mask <= mask_i;
      r1_rm   <= rm_i;
    end
  end

  // Resolve flags by priority zero > Inf/NaN > overflow > underflow
  always_comb begin
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_exp  = 8'd0;
    w_kill = 1'b1;
    if (r1_zero) begin
      w_kill = 1'b1;
    end else if (r1_inf) begin
      w_ovf = 1'b1;
    end else if (r1_s > S_MAX) begin
      w_ovf  = 1'b1;
      w_exp  = r1_s[7:0];
      w_kill = 1'b0;
    end else if (r1_s < S_MIN) begin
      w_unf = 1'b1;
    end else begin
      w_exp  = r1_s[7:0];
      w_kill = 1'b0;
    end
    // Zeroing one factor makes the product 0 for every killed class
    w_ma = w_kill ? '0 : r1_a.sig;
  end

  mant_mul_pipe u_mant_mul_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (w_en),
    .flush_i (flush_i),
    .valid_i (r1_valid),
    .a_i     (w_ma),
    .b_i     (r1_b.sig),
    .valid_o (w_mul_valid),
    .prod_o  (w_prod)
  );

  // Stages 2 and 3 carry flags and pass-through fields beside the multiplier
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r2_exp  <= '0;
      r2_ovf  <= 1'b0;
      r2_unf  <= 1'b0;
      r2_sa   <= 1'b0;
      r2_sb   <= 1'b0;
      r2_ev   <= 1'b0;
      r2_mask <= 1'b0;
      r2_rm   <= '0;
      r3_exp  <= '0;
      r3_ovf  <= 1'b0;
      r3_unf  <= 1'b0;
      r3_sa   <= 1'b0;
      r3_sb   <= 1'b0;
      r3_ev   <= 1'b0;
      r3_mask <= 1'b0;
      r3_rm   <= '0;
    end else if (w_en) begin
      r2_exp  <= w_exp;
      r2_ovf  <= w_ovf;
      r2_unf  <= w_unf;
      r2_sa   <= r1_a.sign;
      r2_sb   <= r1_b.sign;
      r2_ev   <= r1_ev;
      r2_mask <= r1_mask;
      r2_rm   <= r1_rm;
      r3_exp  <= r2_exp;
      r3_ovf  <= r2_ovf;
      r3_unf  <= r2_unf;
      r3_sa   <= r2_sa;
      r3_sb   <= r2_sb;
      r3_ev   <= r2_ev;
      r3_mask <= r2_mask;
      r3_rm   <= r2_rm;
    end
  end

  assign out_valid_o    = w_mul_valid;
  assign mult_result_o  = w_prod;
  assign exponent_sum_o = r3_exp;
  assign overflow_o     = r3_ovf;
  assign underflow_o    = r3_unf;
  assign sa_o           = r3_sa;
  assign sb_o           = r3_sb;
  assign elem_valid_o   = r3_ev;
  assign mask_o         = r3_mask;
  assign round_code_o   = r3_rm;

endmodule

// File: tb/tb_vec_fp32_mul_front.sv
// Self-checking bench for vec_fp32_mul_front: directed cases plus randomized traffic.
module tb_vec_fp32_mul_front;

  logic        clk, rst_n, flush_i, in_valid_i, in_ready_o;
  logic [31:0] a_i, b_i;
  logic        elem_valid_i, mask_i;
  logic [1:0]  rm_i;
  logic        out_valid_o, out_ready_i, sa_o, sb_o, elem_valid_o, mask_o;
  logic [1:0]  round_code_o;
  logic [47:0] mult_result_o;
  logic [7:0]  exponent_sum_o;
  logic        overflow_o, underflow_o;
  logic [63:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] q[$];
  logic        hold = 1'b0;
  logic [63:0] snap = '0;
  logic        saw_stall = 1'b0;
  logic        acc = 1'b0;

  vec_fp32_mul_front dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .a_i            (a_i),
    .b_i            (b_i),
    .elem_valid_i   (elem_valid_i),
    .mask_i         (mask_i),
    .rm_i           (rm_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .sa_o           (sa_o),
    .sb_o           (sb_o),
    .elem_valid_o   (elem_valid_o),
    .mask_o         (mask_o),
    .round_code_o   (round_code_o),
    .mult_result_o  (mult_result_o),
    .exponent_sum_o (exponent_sum_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  assign obs = {sa_o, sb_o, elem_valid_o, mask_o, round_code_o, mult_result_o,
                exponent_sum_o, overflow_o, underflow_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Reference: real FP32 field semantics with plain integer arithmetic
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ev, input logic mk,
                                        input logic [1:0] rm);
    int ea, eb, s;
    longint unsigned ma, mb;
    logic [47:0] p;
    logic [7:0]  x;
    logic        ov, un;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = ea + eb - 127;
    ma = 64'({1'b1, a[22:0]});
    mb = 64'({1'b1, b[22:0]});
    p = '0; x = '0; ov = 1'b0; un = 1'b0;
    if (ea == 0 || eb == 0) begin
      p = '0;
    end else if (ea == 255 || eb == 255) begin
      ov = 1'b1;
    end else if (s > 254) begin
      ov = 1'b1; x = 8'(s); p = 48'(ma * mb);
    end else if (s < 1) begin
      un = 1'b1;
    end else begin
      x = 8'(s); p = 48'(ma * mb);
    end
    return {a[31], b[31], ev, mk, rm, p, x, ov, un};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(1, 10));
      3:       e = 8'($urandom_range(245, 254));
      default: e = 8'($urandom_range(100, 160));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // One clock: inputs already driven at the falling edge; check and book-keep, then advance
  task automatic cycle();
    #1;
    if (hold) chk("stall_frozen", {out_valid_o, obs[62:0]}, {1'b1, snap[62:0]});
    if (out_valid_o && out_ready_i) begin
      if (q.size() == 0) chk("xfer_expected", 64'(q.size()), 64'd1);
      else chk("xfer", obs, q.pop_front());
    end
    hold = out_valid_o && !out_ready_i && !flush_i;
    snap = obs;
    if (!in_ready_o) saw_stall = 1'b1;
    acc = in_valid_i && in_ready_o && !flush_i;
    if (flush_i) q.delete();
    else if (acc) q.push_back(model(a_i, b_i, elem_valid_i, mask_i, rm_i));
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    in_valid_i   = 1'b1;
    a_i          = a;
    b_i          = b;
    elem_valid_i = 1'($urandom);
    mask_i       = 1'($urandom);
    rm_i         = 2'($urandom);
    cycle();
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    flush_i     = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic lat_test(input string tag);
    int k;
    out_ready_i = 1'b1;
    flush_i     = 1'b0;
    drive(32'h3F80_0000, 32'h3F80_0000);
    in_valid_i = 1'b0;
    k = 0;
    while (!out_valid_o && k < 10) begin
      cycle();
      k++;
    end
    chk(tag, 64'(k), 64'd2);
    chk("one_x_one_prod", 64'(mult_result_o), 64'h4000_0000_0000);
    chk("one_x_one_exp", 64'(exponent_sum_o), 64'h7F);
    cycle();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready_o), 64'd1);
    chk({tag, "_data"}, obs, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; elem_valid_i = 1'b0; mask_i = 1'b0; rm_i = '0;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency with an empty pipe
    lat_test("latency");

    // Directed arithmetic and exponent-limit cases, back to back
    out_ready_i = 1'b1;
    drive(32'h3F80_0000, 32'h3F80_0000);
    drive(32'h4000_0000, 32'hC040_0000);
    drive(32'h7F00_0000, 32'h7F00_0000);
    drive(32'h0080_0000, 32'h0080_0000);
    drive(32'h0000_0000, 32'h7F80_0000);
    drive(32'h7FC0_0001, 32'h3F80_0000);
    drain();

    // Back-pressure: five elements, sink stalls for cycles 3-7
    saw_stall = 1'b0;
    begin
      int sent;
      sent = 0;
      for (int c = 1; c <= 30 && (sent < 5 || q.size() > 0); c++) begin
        out_ready_i = !(c >= 3 && c <= 7);
        if (sent < 5) begin
          drive({1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)},
                {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)});
          if (acc) sent++;
        end else begin
          in_valid_i = 1'b0;
          cycle();
        end
      end
      chk("bp_all_sent", 64'(sent), 64'd5);
    end
    chk("bp_ready_dropped", 64'(saw_stall), 64'd1);
    drain();

    // Flush with three elements in flight, flush beats a simultaneous offer
    out_ready_i = 1'b1;
    drive(32'h4000_0000, 32'h4000_0000);
    drive(32'h4040_0000, 32'h4040_0000);
    drive(32'h4080_0000, 32'h4080_0000);
    out_ready_i = 1'b0;
    flush_i     = 1'b1;
    drive(32'h4100_0000, 32'h4100_0000);
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("flush_quiet", 64'(out_valid_o), 64'd0);
      cycle();
    end

    // Randomized traffic with occasional flushes and an asynchronous reset mid-stream
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        q.delete();
        hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        flush_i = 1'b0;
        drain();
        lat_test("post_reset_latency");
      end
      out_ready_i  = ($urandom_range(0, 2) != 0);
      flush_i      = ($urandom_range(0, 49) == 0);
      in_valid_i   = ($urandom_range(0, 3) != 0);
      a_i          = rand_op();
      b_i          = rand_op();
      elem_valid_i = 1'($urandom);
      mask_i       = 1'($urandom);
      rm_i         = 2'($urandom);
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_fp32_mul_front.md
# vec_fp32_mul_front

Upstream stage of the vector FP32 multiply datapath: accepts one lane's pair of FP32 operands per handshake. It unpacks them, computes the biased exponent sum, and forms the exact 48-bit significand product in a 3-stage pipeline. It emits exactly the raw fields the normalize/round/pack result stage consumes (`sa/sb`, element valid, mask, 48-bit product, 8-bit exponent sum, round code, overflow/underflow flags). Pipeline stalls under downstream back-pressure without losing or duplicating elements.

## Interface
- `BIAS`, 127: FP32 exponent bias.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous clear of all pipeline valids.
- `in_valid_i` in 1: operand pair present.
- `in_ready_o` out 1: stage accepts this cycle.
- `a_i`, `b_i` in 32: FP32 operands.
- `elem_valid_i` in 1: element-valid bit, passed through.
- `mask_i` in 1: mask bit, passed through.
- `rm_i` in 2: round code (00 trunc, 01 RNE, 10 +inf, 11 -inf), passed through.
- `out_valid_o` out 1: result fields valid.
- `out_ready_i` in 1: downstream accepts.
- `sa_o`, `sb_o` out 1: operand signs.
- `elem_valid_o`, `mask_o` out 1: passed-through flags.
- `round_code_o` out 2: passed-through round code.
- `mult_result_o` out 48: unsigned significand product.
- `exponent_sum_o` out 8: `EA+EB-BIAS`, low 8 bits.
- `overflow_o` out 1: exponent overflow or Inf/NaN operand.
- `underflow_o` out 1: exponent underflow (result flushed).

## Operation
- Unpack: `S=x[31]`, `E=x[30:23]`, `M={1'b1,x[22:0]}` (24 bits).
- Exponent: 10-bit signed `s = EA + EB - BIAS`.
- Zero/denormal: if `EA==0` or `EB==0`, the element is zero. Result is `mult_result=0`, `exponent_sum=0`, `overflow=0`, `underflow=0`. Denormals are flushed to zero.
- Inf/NaN: if `EA==255` or `EB==255` (and neither operand is zero-class), `overflow=1`. Product and exponent are don't-care but driven 0.
- Otherwise:
  - `overflow = (s > 254)`.
  - `underflow = (s < 1)`. Underflow forces `mult_result=0` and `exponent_sum=0`.
  - Else `exponent_sum = s[7:0]`.
- Product: `MA*MB` formed exactly, 48 bits; bit 47 or 46 is set for normal inputs.
- Priority: zero > Inf/NaN > overflow > underflow.
- `sa_o`/`sb_o`, `elem_valid_o`, `mask_o` and `round_code_o` travel with their element unchanged. Masked-off elements are still computed.

## Timing
- Pipeline:
  - S1 registers unpacked fields, `s`, and class flags.
  - S2 registers two 24x12 partial products (`MA*MB[11:0]`, `MA*MB[23:12]`) plus the flags.
  - S3 registers the summed 48-bit product plus final flags.
- Latency: 3 cycles from accept to `out_valid_o`, with no stall. Throughput is 1 per cycle.
- Global advance `en = ~out_valid_o | out_ready_i`; `in_ready_o = en`. When `en=0` all stages hold, including bubbles.
- Outputs are registered. They stay stable while `out_valid_o && !out_ready_i`.
- Accept occurs when `in_valid_i && in_ready_o`. Transfer occurs when `out_valid_o && out_ready_i`. An accept and a transfer in the same cycle are both legal.
- `flush_i`: all stage valids go to 0 at the next edge. `flush_i` wins over a simultaneous accept. The data registers may retain stale values.
- Reset (async, mid-operation included): all valids 0, and all output data registers 0. `in_ready_o` is 1 during and after reset. In-flight elements are discarded.

## Structure
- Shared package `vecunit_fp_pkg`:
  - constants `FP32_BIAS=127`, `FP32_EXP_MAX=255`, `SIG_W=24`, `PROD_W=48`;
  - round-code localparams;
  - an unpacked-operand struct/typedef (sign, exp, sig).
- One natural sub-module: `mant_mul_pipe`, a 2-stage 24x24 unsigned multiplier (split partial products, registered sum) sharing the `en`/`flush` control. Exponent and flag logic stay in the top module.

## Test plan
- 1.0 x 1.0:
  - Stimulus: `a=0x3F800000`, `b=0x3F800000`.
  - Response, 3 cycles later: `mult_result=48'h400000000000`, `exponent_sum=0x7F`, `sa=sb=0`, flags 0.
- 2.0 x -3.0:
  - Stimulus: `a=0x40000000`, `b=0xC0400000`.
  - Response: `mult_result=48'h600000000000`, `exponent_sum=0x81`, `sa=0`, `sb=1`.
- Exponent limits:
  - `0x7F000000 x 0x7F000000`: `overflow=1`.
  - `0x00800000 x 0x00800000`: `underflow=1`, `mult_result=0`, `exponent_sum=0`.
  - `0x00000000 x 0x7F800000`: zero wins, all flags 0.
- Back-pressure:
  - Stimulus: 5 back-to-back elements with `out_ready_i=0` for cycles 3-7.
  - Response: `in_ready_o` drops once the pipe is full, outputs stay frozen, and all 5 results emerge in order with `mask`/`elem_valid`/`round_code` intact. There are no duplicates and no drops.
- Flush and reset:
  - Stimulus: `flush_i` pulse with 3 elements in flight.
  - Response: no `out_valid_o` for them.
  - Stimulus: `rst_ni` low asynchronously mid-stream.
  - Response: `out_valid_o=0` immediately, outputs 0, and the first post-reset element appears exactly 3 cycles after its accept.
